// File: rtl/led_wave_gen.sv
// Multi-channel LED intensity waveform generator; config writes take effect at phase wrap.
// Define LED_WAVE_PWM_EN to add the on-chip PWM counter and pwm outputs.
module led_wave_gen #(
  parameter  int unsigned CHANNELS = 8,
  parameter  int unsigned VAL_W    = 8,
  parameter  int unsigned PHASE_W  = 27,
  parameter  int unsigned INC_W    = 8,
  localparam int unsigned CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INC_W-1:0]          inc,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CHAN_W-1:0]         cfg_chan,
  input  logic [1:0]                cfg_mode,
  input  logic [VAL_W:0]            cfg_offset,
  output logic [CHANNELS*VAL_W-1:0] value,
  output logic                      wrap
`ifdef LED_WAVE_PWM_EN
  ,
  output logic [CHANNELS-1:0]       pwm
`endif
);

  localparam int unsigned Q_W = VAL_W + 1;

  typedef enum logic [1:0] {
    MODE_TRI = 2'd0,
    MODE_SAW = 2'd1,
    MODE_SQR = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    mode_e             mode;
    logic [Q_W-1:0]    offset;
  } cfg_t;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W:0]   acc_sum_c;
  logic               carry_c;
  logic               inc_zero_c;
  logic               accept_c;
  logic               chan_ok_c;
  logic               direct_c;
  logic               park_c;
  logic               apply_c;
  logic [Q_W-1:0]     p_c;
  cfg_t               cfg_in_c;
  cfg_t               slot;
  mode_e              mode_q   [CHANNELS];
  logic [Q_W-1:0]     offset_q [CHANNELS];
  logic [Q_W-1:0]     q_c      [CHANNELS];

  function automatic logic [VAL_W-1:0] wave_f(input mode_e mode, input logic [Q_W-1:0] q);
    logic             m;
    logic [VAL_W-1:0] l;
    m = q[Q_W-1];
    l = q[VAL_W-1:0];
    case (mode)
      MODE_TRI: wave_f = m ? ~l : l;
      MODE_SAW: wave_f = q[Q_W-1:1];
      MODE_SQR: wave_f = {VAL_W{m}};
      default:  wave_f = '0;
    endcase
  endfunction

  // Wrap detection and config write routing (direct vs. parked in the pending slot)
  always_comb begin
    acc_sum_c  = {1'b0, acc} + (PHASE_W+1)'(inc);
    carry_c    = acc_sum_c[PHASE_W];
    inc_zero_c = (inc == '0);
    p_c        = acc[PHASE_W-1 -: Q_W];
    accept_c   = cfg_valid && cfg_ready;
    chan_ok_c  = 32'(cfg_chan) < CHANNELS;
    direct_c   = accept_c && chan_ok_c && (inc_zero_c || carry_c);
    park_c     = accept_c && chan_ok_c && !(inc_zero_c || carry_c);
    apply_c    = !cfg_ready && (inc_zero_c || carry_c);
    cfg_in_c   = '{chan: cfg_chan, mode: mode_e'(cfg_mode), offset: cfg_offset};
    for (int i = 0; i < CHANNELS; i++) begin
      q_c[i] = p_c + offset_q[i];
    end
  end

  // cfg_ready doubles as the inverted pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      wrap      <= 1'b0;
      cfg_ready <= 1'b1;
      slot      <= '0;
      value     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_TRI;
        offset_q[i] <= '0;
      end
    end else begin
      acc  <= acc_sum_c[PHASE_W-1:0];
      wrap <= carry_c;
      if (park_c) begin
        slot      <= cfg_in_c;
        cfg_ready <= 1'b0;
      end else if (apply_c) begin
        cfg_ready <= 1'b1;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (direct_c && cfg_chan == CHAN_W'(i)) begin
          mode_q[i]   <= cfg_in_c.mode;
          offset_q[i] <= cfg_in_c.offset;
        end else if (apply_c && slot.chan == CHAN_W'(i)) begin
          mode_q[i]   <= slot.mode;
          offset_q[i] <= slot.offset;
        end
        value[i*VAL_W +: VAL_W] <= wave_f(mode_q[i], q_c[i]);
      end
    end
  end

`ifdef LED_WAVE_PWM_EN
  logic [VAL_W-1:0] pwm_cnt;

  // Free-running PWM compare against the registered intensities
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + VAL_W'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        pwm[i] <= (pwm_cnt < value[i*VAL_W +: VAL_W]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_led_wave_gen.sv
// Scoreboard bench for led_wave_gen: a cycle model pushes expected outputs, a negedge checker pops them.
module tb_led_wave_gen;

  localparam int unsigned CH = 4;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic [7:0]  inc        = 8'd0;
  logic        cfg_valid  = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_chan   = 2'd0;
  logic [1:0]  cfg_mode   = 2'd0;
  logic [8:0]  cfg_offset = 9'd0;
  logic [31:0] value;
  logic        wrap;
  logic        cfg_valid3 = 1'b0;
  logic [1:0]  cfg_chan3  = 2'd0;
  logic        cfg_ready3;
  logic [23:0] value3;
  logic        wrap3;
`ifdef LED_WAVE_PWM_EN
  logic [3:0]  pwm;
  logic [2:0]  pwm3;
`endif

  led_wave_gen #(.CHANNELS(4), .VAL_W(8), .PHASE_W(10), .INC_W(8)) dut (
    .clk(clk), .rst(rst), .inc(inc), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_offset(cfg_offset),
    .value(value), .wrap(wrap)
`ifdef LED_WAVE_PWM_EN
    , .pwm(pwm)
`endif
  );

  // Three-channel instance so a channel index past the last channel is expressible
  led_wave_gen #(.CHANNELS(3), .VAL_W(8), .PHASE_W(10), .INC_W(8)) dut3 (
    .clk(clk), .rst(rst), .inc(inc), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_chan(cfg_chan3), .cfg_mode(cfg_mode), .cfg_offset(cfg_offset),
    .value(value3), .wrap(wrap3)
`ifdef LED_WAVE_PWM_EN
    , .pwm(pwm3)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] val;
    logic [23:0] val3;
    logic        wrap;
    logic        rdy;
    logic [3:0]  pwm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  int m_acc = 0;
  int m_mode [CH] = '{default: 0};
  int m_off  [CH] = '{default: 0};
  int m_val  [CH] = '{default: 0};
  int m_cnt  = 0;
  bit m_pend = 1'b0;
  int s_chan = 0;
  int s_mode = 0;
  int s_off  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int wave_m(input int mode, input int q);
    case (mode)
      0:       return (q < 256) ? q : 511 - q;
      1:       return q / 2;
      2:       return (q >= 256) ? 255 : 0;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock with the currently driven inputs, then take the edge
  task automatic cycle();
    exp_t       e;
    int         nv [CH];
    bit         carry;
    bit         zero;
    bit         accept;
    logic [7:0] tv;
    e.due = cyc + 1;
    if (rst) begin
      m_acc  = 0;
      m_pend = 1'b0;
      m_cnt  = 0;
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = 0;
        m_off[i]  = 0;
        m_val[i]  = 0;
      end
      e.val  = '0;
      e.val3 = '0;
      e.wrap = 1'b0;
      e.rdy  = 1'b1;
      e.pwm  = '0;
    end else begin
      carry = (m_acc + int'(inc)) >= 1024;
      zero  = (inc == 8'd0);
      for (int i = 0; i < CH; i++) begin
        nv[i]    = wave_m(m_mode[i], ((m_acc / 2) + m_off[i]) % 512);
        e.pwm[i] = (m_cnt < m_val[i]);
      end
      tv     = 8'(wave_m(0, m_acc / 2));
      e.val3 = {tv, tv, tv};
      e.wrap = carry;
      accept = cfg_valid && !m_pend;
      if (m_pend && (zero || carry)) begin
        m_mode[s_chan] = s_mode;
        m_off[s_chan]  = s_off;
        m_pend         = 1'b0;
      end
      if (accept && int'(cfg_chan) < CH) begin
        if (zero || carry) begin
          m_mode[int'(cfg_chan)] = int'(cfg_mode);
          m_off[int'(cfg_chan)]  = int'(cfg_offset);
        end else begin
          s_chan = int'(cfg_chan);
          s_mode = int'(cfg_mode);
          s_off  = int'(cfg_offset);
          m_pend = 1'b1;
        end
      end
      m_acc = (m_acc + int'(inc)) % 1024;
      m_cnt = (m_cnt + 1) % 256;
      for (int i = 0; i < CH; i++) begin
        m_val[i]          = nv[i];
        e.val[i*8 +: 8]   = 8'(nv[i]);
      end
      e.rdy = !m_pend;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Hold a write until the DUT takes it; waited counts the stalled cycles
  task automatic write(input int ch, input int md, input int off, output int waited);
    cfg_chan   = 2'(ch);
    cfg_mode   = 2'(md);
    cfg_offset = 9'(off);
    cfg_valid  = 1'b1;
    waited     = 0;
    while (!cfg_ready && waited < 2000) begin
      cycle();
      waited++;
    end
    if (!cfg_ready) check("wr_timeout", 32'(cfg_ready), 32'd1);
    cycle();
    cfg_valid = 1'b0;
  endtask

  always @(negedge clk) begin : sb_chk
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("value",  value, e.val);
      check("value3", 32'(value3), 32'(e.val3));
      check("wrap",   32'(wrap), 32'(e.wrap));
      check("ready",  32'(cfg_ready), 32'(e.rdy));
`ifdef LED_WAVE_PWM_EN
      check("pwm",    32'(pwm), 32'(e.pwm));
`endif
    end
  end

  initial begin : main
    int w1;
    int w2;
    int nw;
    int waited;
    int exp_w;
    int hi;
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(2);

    // Free-running triangle on every channel, wrap every 512 cycles
    rst = 1'b0;
    inc = 8'd2;
    w1  = -1;
    w2  = -1;
    nw  = 0;
    for (int k = 0; k < 1100; k++) begin
      cycle();
      if (wrap) begin
        nw++;
        if (w1 < 0) w1 = k;
        else if (w2 < 0) w2 = k;
      end
    end
    check("wrap_count", 32'(nw), 32'd2);
    check("wrap_period", 32'(w2 - w1), 32'd512);

    // Immediate write while frozen: ch1 half a period ahead of ch0
    inc = 8'd0;
    write(1, 0, 256, waited);
    check("imm_wait", 32'(waited), 32'd0);
    inc = 8'd2;
    run(600);

    // Mode change at p=100 held until the wrap
    for (int n = 0; n < 2000 && m_acc != 200; n++) cycle();
    write(2, 2, 0, waited);
    run(600);

    // Back-to-back writes: second stalls until the cycle after the apply edge
    write(3, 3, 0, waited);
    exp_w = m_pend ? (1024 - m_acc) / 2 : 0;
    write(0, 1, 10, waited);
    check("stall_wait", 32'(waited), 32'(exp_w));
    run(600);

    // Out-of-range channel on the three-channel instance, running and frozen
    cfg_chan3  = 2'd3;
    cfg_mode   = 2'd3;
    cfg_offset = 9'd100;
    cfg_valid3 = 1'b1;
    cycle();
    inc = 8'd0;
    cycle();
    cfg_valid3 = 1'b0;
    inc = 8'd2;
    run(600);

    // Reset while a write is pending drops it
    write(0, 2, 0, waited);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(600);

`ifdef LED_WAVE_PWM_EN
    rst = 1'b1;
    inc = 8'd0;
    cycle();
    rst = 1'b0;
    write(0, 0, 64, waited);
    run(3);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      cycle();
      hi += int'(pwm[0]);
    end
    check("pwm_hi64", 32'(hi), 32'd64);
    write(0, 0, 0, waited);
    run(3);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      cycle();
      hi += int'(pwm[0]);
    end
    check("pwm_hi0", 32'(hi), 32'd0);
`endif

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
